// File: rtl/ks_pkg.sv
// Shared types and sizing helpers for the digit-serial Kogge-Stone adder.
package ks_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ks_ndig(input int width);
        return width / DIGIT_W;
    endfunction

    function automatic int ks_idx_w(input int width);
        int n;
        n = width / DIGIT_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ks_add4.sv
// 4-bit Kogge-Stone slice: carry-in folded into bit-0 generate,
// then two prefix levels (distance 1 and 2).
module ks_add4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] g1;
    logic [3:2] p1;
    logic [3:0] g2;

    assign p = A ^ B;
    assign g = (A & B) | {3'b000, p[0] & Cin};

    assign g1[0] = g[0];
    assign g1[1] = g[1] | (p[1] & g[0]);
    assign g1[2] = g[2] | (p[2] & g[1]);
    assign g1[3] = g[3] | (p[3] & g[2]);
    assign p1[2] = p[2] & p[1];
    assign p1[3] = p[3] & p[2];

    assign g2[1:0] = g1[1:0];
    assign g2[2]   = g1[2] | (p1[2] & g1[0]);
    assign g2[3]   = g1[3] | (p1[3] & g1[1]);

    assign Sum  = p ^ {g2[2:0], Cin};
    assign Cout = g2[3];

endmodule

// File: rtl/ks_digit_serial_adder.sv
// Digit-serial multi-precision adder sharing one 4-bit Kogge-Stone slice.
// Optional subtract mode (sub port) enabled by defining KS_SUB_EN.
module ks_digit_serial_adder
    import ks_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef KS_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NDIG = ks_ndig(WIDTH);
    localparam int IW   = ks_idx_w(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    generate
        if (WIDTH < DIGIT_W || (WIDTH % DIGIT_W) != 0) begin : g_bad_width
            $error("WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t          state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic [IW-1:0]    idx;
    logic [IW+1:0]    base;
    logic [3:0]       s4;
    logic             c4;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef KS_SUB_EN
    // a - b == a + ~b + 1; cin has no meaning in subtract mode
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign base = {idx, 2'b00};

    ks_add4 u_slice (
        .A   (a_q[base +: 4]),
        .B   (b_q[base +: 4]),
        .Cin (c_q),
        .Sum (s4),
        .Cout(c4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b_in;
                        c_q   <= c_in;
                        idx   <= '0;
                        sum_q <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[base +: 4] <= s4;
                    c_q              <= c4;
                    if (idx == LAST) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign cout      = out_valid & c_q;

endmodule

// File: doc/ks_digit_serial_adder.md
# ks_digit_serial_adder

Digit-serial multi-precision adder controller. It accepts WIDTH-bit operands over a valid/ready handshake and adds them 4 bits per cycle through a single shared 4-bit Kogge-Stone carry-lookahead slice, chaining the carry through a register between digits. The block sits between an operand producer and a result consumer. It lets wide additions reuse one small prefix adder instead of a full-width parallel adder.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to digit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the top digit.
- busy  out  1  high whenever state is not IDLE.

## Operation
- NDIG = WIDTH/4. Internal state: operand registers a_q/b_q, carry register c_q, digit counter idx of width clog2(NDIG), with a minimum width of 1.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b and cin into a_q, b_q and c_q; clear idx and sum; go to RUN.
- RUN:
  - Each cycle, feed digit idx of a_q and b_q plus c_q to the 4-bit slice.
  - Write the slice sum into sum[4*idx+3:4*idx].
  - Load the slice carry-out into c_q.
  - If idx==NDIG-1, go to DONE; otherwise increment idx.
  - in_valid is ignored in this state.
- DONE:
  - out_valid=1 and cout=c_q.
  - sum and cout hold stable until out_valid&&out_ready; on that handshake go to IDLE.
- Arithmetic: the result is (a+b+cin) mod 2^WIDTH, with cout the bit-WIDTH carry. It must be bit-exact with a full-width add.
- Operand registers are not modified during RUN or DONE. Input changes after acceptance have no effect.
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, state=IDLE, idx=0, c_q=0.
- Reset asserted mid-operation aborts immediately to the reset values. The partial result is discarded and never presented.

## Timing
- Acceptance cycle T. RUN occupies cycles T+1..T+NDIG. out_valid rises in cycle T+NDIG+1.
- Latency from accept to out_valid is NDIG+1 cycles. WIDTH=16 gives 5.
- There is no input/output bypass: in_ready rises the cycle after the output handshake.
- Maximum throughput is one operation per NDIG+2 cycles when out_ready is held high.
- out_ready held low: DONE is held indefinitely with outputs stable, and in_ready stays 0.
- out_ready high before DONE has no effect.
- NDIG=1 (WIDTH=4): RUN lasts exactly one cycle and idx is constant 0.
- The slice is purely combinational. The critical path is c_q → slice → c_q/sum, independent of WIDTH.

## Configuration
- KS_SUB_EN:
  - Defined: adds input port sub (1 bit, sampled at acceptance and held in a register). When sub=1, b is inverted at latch and c_q is loaded with 1, so the result is a-b in two's complement. In this mode cout=1 means no borrow; cin is ignored.
  - Undefined: the sub port does not exist and the block is add-only.
  - Latency and handshake are identical in both builds.

## Structure
- Shared package ks_pkg:
  - state enum (IDLE/RUN/DONE);
  - DIGIT_W=4 constant;
  - a function computing NDIG and the counter width from WIDTH.
- Sub-module ks_add4: the 4-bit Kogge-Stone slice.
  - Ports: A[3:0], B[3:0], Cin in; Sum[3:0], Cout out.
  - Two prefix levels (distance 1, 2); sum = P ^ carries.
  - Instantiated once; all sequencing lives in the top module.

## Test plan
All scenarios use WIDTH=16.
- Basic add: a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, out_valid exactly 5 cycles after accept.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. This exercises carry chaining across all 4 digits.
- Backpressure: out_ready=0 for 10 cycles after DONE. Required: sum/cout stable, in_ready=0, and in_valid pulses ignored. Raising out_ready gives one handshake, then in_ready=1 the next cycle.
- Reset mid-RUN: deassert rst_n at idx=2. Required: immediately out_valid=0, sum=0, in_ready=1. The next operation, a=0x0001 and b=0x0001, gives 0x0002.
- Back-to-back random: 1000 random a/b/cin with out_ready always 1. Each result must be compared to a+b+cin, with spacing exactly 6 cycles per op.
- KS_SUB_EN build: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
